hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/pipeline_ctrl_pkg.sv | 38 +++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/load_use_detect.sv | 16 +
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - pipeline control states, control bundle and defaults
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    // Bit positions inside the 4-bit stage enable / flush vectors
    localparam int STG_IF_ID  = 3;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 1;
    localparam int STG_MEM_WB = 0;

    typedef struct packed {
        logic       pc_enable;
        logic [3:0] enable;
        logic [3:0] flush;
        logic       halt_cpu;
    } hazard_ctl_t;

    // Everything held, nothing flushed: reset and HALTED baseline
    localparam hazard_ctl_t CTL_IDLE = '{pc_enable: 1'b0, enable: 4'b0000,
                                         flush: 4'b0000, halt_cpu: 1'b0};

    // Normal advance of every stage
    function automatic hazard_ctl_t ctl_advance();
        hazard_ctl_t c;
        c.pc_enable = 1'b1;
        c.enable    = 4'b1111;
        c.flush     = 4'b0000;
        c.halt_cpu  = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - signal bundle for hazard_ctrl (counters present with HAZARD_PERF_EN)
interface hazard_ctrl_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic     ihit;
    logic     dhit;
    logic     dREN_EX_MEM;
    logic     dWEN_EX_MEM;
    logic     memread_ID_EX;
    regbits_t Rt_ID_EX;
    regbits_t Rs_IF_ID;
    regbits_t Rt_IF_ID;
    logic     branch_taken_EX;
    logic     halt_EX_MEM;
    logic     halt_MEM_WB;
    logic     pc_enable;
    logic     enable_IF_ID;
    logic     enable_ID_EX;
    logic     enable_EX_MEM;
    logic     enable_MEM_WB;
    logic     flush_IF_ID;
    logic     flush_ID_EX;
    logic     flush_EX_MEM;
    logic     flush_MEM_WB;
    logic     halt_cpu;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport hc (
        input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, memread_ID_EX,
               Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX,
               halt_EX_MEM, halt_MEM_WB,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM,
               enable_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
               flush_MEM_WB, halt_cpu
    );

endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - detects an instruction in IF/ID reading a register loaded by ID/EX
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     memread_ID_EX,
    input  regbits_t Rt_ID_EX,
    input  regbits_t Rs_IF_ID,
    input  regbits_t Rt_IF_ID,
    output logic     load_use
);

    // Register 0 is hardwired to zero, so a load into it never creates a dependency
    assign load_use = memread_ID_EX && (Rt_ID_EX != '0) &&
                      ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller; HAZARD_PERF_EN adds stall/flush counters
module hazard_ctrl
    import cpu_types_pkg::*;
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     dREN_EX_MEM,
    input  logic     dWEN_EX_MEM,
    input  logic     memread_ID_EX,
    input  regbits_t Rt_ID_EX,
    input  regbits_t Rs_IF_ID,
    input  regbits_t Rt_IF_ID,
    input  logic     branch_taken_EX,
    input  logic     halt_EX_MEM,
    input  logic     halt_MEM_WB,
    output logic     pc_enable,
    output logic     enable_IF_ID,
    output logic     enable_ID_EX,
    output logic     enable_EX_MEM,
    output logic     enable_MEM_WB,
    output logic     flush_IF_ID,
    output logic     flush_ID_EX,
    output logic     flush_EX_MEM,
    output logic     flush_MEM_WB,
    output logic     halt_cpu
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    hazard_state_t state_q, state_d;
    hazard_ctl_t   ctl;
    logic          mem_pend;
    logic          load_use;
    logic          br_flush;

    assign mem_pend = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;

    load_use_detect u_load_use_detect (
        .memread_ID_EX (memread_ID_EX),
        .Rt_ID_EX      (Rt_ID_EX),
        .Rs_IF_ID      (Rs_IF_ID),
        .Rt_IF_ID      (Rt_IF_ID),
        .load_use      (load_use)
    );

    // Mealy control decode; a flushed stage keeps its enable high since the flush wins in the register
    always_comb begin
        ctl      = CTL_IDLE;
        state_d  = state_q;
        br_flush = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                ctl     = ctl_advance();
                state_d = RUN;
                if (mem_pend) begin
                    ctl.pc_enable = 1'b0;
                    ctl.enable    = 4'b0001;
                    ctl.flush     = 4'b0001;
                    state_d       = MEM_WAIT;
                end else if (halt_EX_MEM) begin
                    ctl.pc_enable = 1'b0;
                    ctl.flush     = 4'b1110;
                    state_d       = DRAIN;
                end else if (branch_taken_EX) begin
                    // A load-use hit here is moot: the dependent instruction is flushed
                    ctl.pc_enable = ihit;
                    ctl.flush     = 4'b1100;
                    br_flush      = 1'b1;
                end else if (load_use) begin
                    ctl.pc_enable           = 1'b0;
                    ctl.enable[STG_IF_ID]   = 1'b0;
                    ctl.flush[STG_ID_EX]    = 1'b1;
                end else if (!ihit) begin
                    ctl.pc_enable           = 1'b0;
                    ctl.flush[STG_IF_ID]    = 1'b1;
                end
            end
            DRAIN: begin
                ctl           = ctl_advance();
                ctl.pc_enable = 1'b0;
                ctl.flush     = 4'b1110;
                if (halt_MEM_WB) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                ctl.halt_cpu = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!nRST) begin
            ctl      = CTL_IDLE;
            br_flush = 1'b0;
        end
    end

    // State register; reset drops straight back to RUN from any state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_enable     = ctl.pc_enable;
    assign enable_IF_ID  = ctl.enable[STG_IF_ID];
    assign enable_ID_EX  = ctl.enable[STG_ID_EX];
    assign enable_EX_MEM = ctl.enable[STG_EX_MEM];
    assign enable_MEM_WB = ctl.enable[STG_MEM_WB];
    assign flush_IF_ID   = ctl.flush[STG_IF_ID];
    assign flush_ID_EX   = ctl.flush[STG_ID_EX];
    assign flush_EX_MEM  = ctl.flush[STG_EX_MEM];
    assign flush_MEM_WB  = ctl.flush[STG_MEM_WB];
    assign halt_cpu      = ctl.halt_cpu;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters of PC stall cycles and branch flushes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctl.pc_enable && (state_q != HALTED) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (br_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Keeps CNT_W referenced when the counters are compiled out
    logic [CNT_W-1:0] perf_unused;
    assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (HAZARD_PERF_EN aware)
module tb_hazard_ctrl;

    localparam int CNT_W = 3;

    // {pc, en IF/ID ID/EX EX/MEM MEM/WB, fl IF/ID ID/EX EX/MEM MEM/WB, halt}
    localparam logic [9:0] O_ZERO   = 10'b0_0000_0000_0;
    localparam logic [9:0] O_NORM   = 10'b1_1111_0000_0;
    localparam logic [9:0] O_MEMP   = 10'b0_0001_0001_0;
    localparam logic [9:0] O_HALTX  = 10'b0_1111_1110_0;
    localparam logic [9:0] O_BR1    = 10'b1_1111_1100_0;
    localparam logic [9:0] O_BR0    = 10'b0_1111_1100_0;
    localparam logic [9:0] O_LU     = 10'b0_0111_0100_0;
    localparam logic [9:0] O_NOIH   = 10'b0_1111_1000_0;
    localparam logic [9:0] O_DRAIN  = 10'b0_1111_1110_0;
    localparam logic [9:0] O_HALTED = 10'b0_0000_0000_1;

    typedef struct {
        logic       ihit, dhit, dren, dwen, memread;
        logic [4:0] rt_idex, rs_ifid, rt_ifid;
        logic       br, hx, hm;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];
    vec_t       vecs[16];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ihit            (hif.ihit),
        .dhit            (hif.dhit),
        .dREN_EX_MEM     (hif.dREN_EX_MEM),
        .dWEN_EX_MEM     (hif.dWEN_EX_MEM),
        .memread_ID_EX   (hif.memread_ID_EX),
        .Rt_ID_EX        (hif.Rt_ID_EX),
        .Rs_IF_ID        (hif.Rs_IF_ID),
        .Rt_IF_ID        (hif.Rt_IF_ID),
        .branch_taken_EX (hif.branch_taken_EX),
        .halt_EX_MEM     (hif.halt_EX_MEM),
        .halt_MEM_WB     (hif.halt_MEM_WB),
        .pc_enable       (hif.pc_enable),
        .enable_IF_ID    (hif.enable_IF_ID),
        .enable_ID_EX    (hif.enable_ID_EX),
        .enable_EX_MEM   (hif.enable_EX_MEM),
        .enable_MEM_WB   (hif.enable_MEM_WB),
        .flush_IF_ID     (hif.flush_IF_ID),
        .flush_ID_EX     (hif.flush_ID_EX),
        .flush_EX_MEM    (hif.flush_EX_MEM),
        .flush_MEM_WB    (hif.flush_MEM_WB),
        .halt_cpu        (hif.halt_cpu)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt       (hif.stall_cnt),
        .flush_cnt       (hif.flush_cnt)
`endif
    );

    function automatic in_t mk(input logic ihit, input logic dhit, input logic dren,
                               input logic dwen, input logic memread,
                               input logic [4:0] rt_idex, input logic [4:0] rs_ifid,
                               input logic [4:0] rt_ifid, input logic br,
                               input logic hx, input logic hm);
        in_t v;
        v.ihit = ihit; v.dhit = dhit; v.dren = dren; v.dwen = dwen;
        v.memread = memread; v.rt_idex = rt_idex; v.rs_ifid = rs_ifid;
        v.rt_ifid = rt_ifid; v.br = br; v.hx = hx; v.hm = hm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        hif.ihit            = v.ihit;
        hif.dhit            = v.dhit;
        hif.dREN_EX_MEM     = v.dren;
        hif.dWEN_EX_MEM     = v.dwen;
        hif.memread_ID_EX   = v.memread;
        hif.Rt_ID_EX        = v.rt_idex;
        hif.Rs_IF_ID        = v.rs_ifid;
        hif.Rt_IF_ID        = v.rt_ifid;
        hif.branch_taken_EX = v.br;
        hif.halt_EX_MEM     = v.hx;
        hif.halt_MEM_WB     = v.hm;
    endtask

    task automatic compare_out();
        logic [9:0] act;
        logic [9:0] e;
        string      nm;
        act = {hif.pc_enable, hif.enable_IF_ID, hif.enable_ID_EX, hif.enable_EX_MEM,
               hif.enable_MEM_WB, hif.flush_IF_ID, hif.flush_ID_EX, hif.flush_EX_MEM,
               hif.flush_MEM_WB, hif.halt_cpu};
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, {22'd0, act}, {22'd0, e});
        end
    endtask

    // One cycle: apply reset level and inputs after the falling edge, check before the rising edge
    task automatic step(input logic rst_n, input in_t v, input logic [9:0] e, input string nm);
        @(negedge CLK);
        nRST = rst_n;
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        #2;
        compare_out();
    endtask

    task automatic set_vec(input int i, input in_t v, input logic [9:0] e);
        vecs[i].in  = v;
        vecs[i].exp = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t n;
        in_t nih;
        in_t mp;
        in_t brv;
        n   = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        nih = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        mp  = mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        brv = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);

        //                 ihit dhit dren dwen mrd rt_idex rs_ifid rt_ifid br hx hm
        set_vec(0,  mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM);
        set_vec(1,  mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NOIH);
        set_vec(2,  mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0), O_LU);
        set_vec(3,  mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM);
        set_vec(4,  mk(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0), O_LU);
        set_vec(5,  mk(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd4, 0, 0, 0), O_NORM);
        set_vec(6,  mk(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0), O_NORM);
        set_vec(7,  mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_BR1);
        set_vec(8,  mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_BR0);
        set_vec(9,  mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0), O_BR1);
        set_vec(10, mk(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM);
        set_vec(11, mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_MEMP);
        set_vec(12, mk(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM);
        set_vec(13, mk(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0), O_LU);
        set_vec(14, mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_MEMP);
        set_vec(15, mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NOIH);

        // Reset state at time zero
        nRST = 1'b0;
        drive(n);
        exp_q.push_back(O_ZERO);
        name_q.push_back("reset_outputs");
        #2;
        compare_out();
`ifdef HAZARD_PERF_EN
        chk("reset_stall_cnt", {29'd0, hif.stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {29'd0, hif.flush_cnt}, 32'd0);
`endif

        step(1, n, O_NORM, "release_norm");

        for (int i = 0; i < 16; i++) begin
            step(1, vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Three cycles of load miss, then the completing cycle advances normally
        for (int i = 0; i < 3; i++) begin
            step(1, mp, O_MEMP, $sformatf("memwait%0d", i));
        end
        step(1, mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0), O_NORM, "memwait_dhit");
        step(1, n, O_NORM, "memwait_after");

        // Reset in the middle of MEM_WAIT
        step(1, mp, O_MEMP, "rstmw_enter");
        step(1, mp, O_MEMP, "rstmw_hold");
        step(0, mp, O_ZERO, "rstmw_reset");
        step(1, n, O_NORM, "rstmw_release");
        step(1, nih, O_NOIH, "rstmw_noihit");

        // Reset in the middle of DRAIN
        step(1, mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_HALTX, "rstdr_halt_ex");
        step(1, n, O_DRAIN, "rstdr_drain");
        step(0, n, O_ZERO, "rstdr_reset");
        step(1, n, O_NORM, "rstdr_release");
        step(1, nih, O_NOIH, "rstdr_noihit");

        // Halt sequence into sticky HALTED
        step(1, mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_HALTX, "halt_ex");
        step(1, mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_DRAIN, "halt_drain");
        for (int i = 0; i < 10; i++) begin
            step(1, mk(logic'(i % 2), 0, logic'(i % 3 == 0), 0, 0, 5'd0, 5'd0, 5'd0,
                       logic'(i % 4 == 1), 0, 0), O_HALTED, $sformatf("halted%0d", i));
        end

        // Reset leaves HALTED
        step(0, n, O_ZERO, "halted_reset");
        step(1, n, O_NORM, "halted_release");

`ifdef HAZARD_PERF_EN
        chk("perf_start_stall", {29'd0, hif.stall_cnt}, 32'd0);
        chk("perf_start_flush", {29'd0, hif.flush_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, nih, O_NOIH, $sformatf("perf_stall%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            step(1, brv, O_BR1, $sformatf("perf_br%0d", i));
        end
        step(1, n, O_NORM, "perf_norm1");
        chk("perf_stall_cnt4", {29'd0, hif.stall_cnt}, 32'd4);
        chk("perf_flush_cnt2", {29'd0, hif.flush_cnt}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            step(1, nih, O_NOIH, $sformatf("perf_sat_stall%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            step(1, brv, O_BR1, $sformatf("perf_sat_br%0d", i));
        end
        step(1, n, O_NORM, "perf_norm2");
        chk("perf_stall_sat", {29'd0, hif.stall_cnt}, 32'd7);
        chk("perf_flush_sat", {29'd0, hif.flush_cnt}, 32'd7);
`endif

        if (exp_q.size() != 0) begin
            chk("scoreboard_leftover", exp_q.size(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
